// File: rtl/zero_cmp_arbiter_pkg.sv
// zero_cmp_arbiter_pkg
//   Shared definitions for the zero-compare arbiter slice: the width of the
//   shared compare unit, the flag type it returns, and the one operand value
//   that clears the flag.
package zero_cmp_arbiter_pkg;

  localparam int CMP_W = 8;

  typedef logic cmp_flag_t;

  // Operand value for which the compare unit reports flag = 0.
  localparam logic [CMP_W-1:0] CMP_ALL_ONES = 8'hFF;

endpackage

// File: rtl/zero_cmp_arbiter_if.sv
// zero_cmp_arbiter_if
//   Request/response bundle between N_REQ requesters and the shared compare
//   unit arbiter.
//
//   Handshake: requester i holds req_valid[i] with a stable operand in
//   req_data[i*W +: W]; the operand is taken on the rising edge where
//   req_valid[i] && req_ready[i]. req_ready is one-hot or zero. The result
//   comes back exactly one cycle later as a one-hot single-cycle pulse on
//   resp_valid with the flag on resp_z; there is no response backpressure.
//
//   master modport : requester side (drives req_valid, req_data)
//   slave modport  : arbiter side (drives req_ready, resp_valid, resp_z)
interface zero_cmp_arbiter_if
  import zero_cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = CMP_W
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   resp_valid;
  cmp_flag_t          resp_z;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  resp_valid,
    input  resp_z
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output resp_valid,
    output resp_z
  );

endinterface

// File: rtl/zero_cmp_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter for a shared unit that accepts one request per cycle.
//   The grant is combinational from the request vector and the registered
//   pointer; the search starts at ptr and wraps modulo N. After a grant to g
//   the pointer moves to (g+1) mod N; with no grant it holds.
//
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   grant      : one-hot grant, zero when no request is set
//   grant_idx  : binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] N_L  = SUM_W'(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] ptr;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // ptr < N and offset < N, so one conditional subtract gives the modulo.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= N_L) begin
        sum = sum - N_L;
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // A grant is only ever issued to a set request, so found == transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/zero_cmp_arbiter.sv
// zero_cmp_arbiter
//   Shares the single 8-bit zero-compare unit among N_REQ requesters. A
//   round-robin arbiter accepts one operand per cycle into op_q; the flag
//   (0 iff operand == 8'hFF) is returned to the granted requester one cycle
//   later as a one-hot pulse on resp_valid.
//
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   busy       : a compare result is being presented this cycle
//   cmp_count  : completed compares since reset, saturating at all-ones
module zero_cmp_arbiter
  import zero_cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = CMP_W,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  zero_cmp_arbiter_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   cmp_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             xfer;

  logic [W-1:0]     op_q;
  logic [PTR_W-1:0] idx_q;
  logic             vld_q;
  logic [CNT_W-1:0] cmp_count_q;
  cmp_flag_t        flag;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;

  // Input register of the compare unit. A new transfer may land in the same
  // edge that ends a response pulse; requesters have already sampled it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= xfer;
      if (xfer) begin
        op_q  <= bus.req_data[int'(grant_idx) * W +: W];
        idx_q <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_count_q <= '0;
    end else if (vld_q && (cmp_count_q != {CNT_W{1'b1}})) begin
      cmp_count_q <= cmp_count_q + 1'b1;
    end
  end

  // Shared compare unit: flag clears only for the all-ones operand.
  assign flag = (op_q != CMP_ALL_ONES);

  assign bus.resp_valid = vld_q ? (N_REQ'(1) << idx_q) : '0;
  assign bus.resp_z     = vld_q & flag;
  assign busy           = vld_q;
  assign cmp_count      = cmp_count_q;

endmodule

// File: tb/tb_zero_cmp_arbiter.sv
// tb_zero_cmp_arbiter
//   Directed bench for zero_cmp_arbiter with N_REQ = 4, W = 8, CNT_W = 16.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_zero_cmp_arbiter;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] cmp_count;

  int n_cmp = 0;
  int n_bad = 0;

  zero_cmp_arbiter_if #(.N_REQ(4), .W(8)) bus ();

  zero_cmp_arbiter #(.N_REQ(4), .W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1010;
    bus.req_data  = $urandom;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b0) begin n_bad++; $display("FAIL reset_resp_z got %b want 0", bus.resp_z); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (cmp_count !== 16'h0000) begin n_bad++; $display("FAIL reset_count got %h want 0000", cmp_count); end
    // Pointer is 0 in reset: the lowest valid requester is offered a grant.
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL reset_ready got %b want 0010", bus.req_ready); end
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_idle got %b want 0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL idle_resp_valid got %b want 0000", bus.resp_valid); end
  endtask

  // Pointer 0 -> grant 2 -> pointer 3.
  task automatic test_single();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_data  = {8'h77, 8'h00, 8'hFF, 8'hFF};
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0100) begin n_bad++; $display("FAIL single_resp_valid got %b want 0100", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b1) begin n_bad++; $display("FAIL single_resp_z got %b want 1", bus.resp_z); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_pulse_end got %b want 0000", bus.resp_valid); end
    n_cmp++; if (cmp_count !== 16'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", cmp_count); end
  endtask

  // Pointer 3, only requester 1 valid: search 3,0,1 -> grant 1, pointer 2.
  task automatic test_all_ones();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data  = {8'h00, 8'h00, 8'hFF, 8'h00};
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL ones_ready got %b want 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0010) begin n_bad++; $display("FAIL ones_resp_valid got %b want 0010", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b0) begin n_bad++; $display("FAIL ones_resp_z got %b want 0", bus.resp_z); end
    @(negedge clk);
    #1;
    n_cmp++; if (cmp_count !== 16'd2) begin n_bad++; $display("FAIL ones_count got %0d want 2", cmp_count); end
  endtask

  // Fresh reset, then all four valid for 8 cycles: grants 0,1,2,3,0,1,2,3.
  // Operands r0=00, r1=FF, r2=5A, r3=FF give flags 1,0,1,0.
  task automatic test_fairness();
    logic [3:0] g_tab [8];
    logic       z_tab [4];
    logic [3:0] exp_resp;
    logic       exp_z;
    g_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    z_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'hFF, 8'h5A, 8'hFF, 8'h00};
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_resp = (k == 0) ? 4'b0000 : g_tab[(k + 7) % 8];
      exp_z    = (k == 0) ? 1'b0 : z_tab[(k + 3) % 4];
      n_cmp++; if (bus.req_ready !== g_tab[k]) begin n_bad++; $display("FAIL fair_ready[%0d] got %b want %b", k, bus.req_ready, g_tab[k]); end
      n_cmp++; if (bus.resp_valid !== exp_resp) begin n_bad++; $display("FAIL fair_resp_valid[%0d] got %b want %b", k, bus.resp_valid, exp_resp); end
      n_cmp++; if (bus.resp_z !== exp_z) begin n_bad++; $display("FAIL fair_resp_z[%0d] got %b want %b", k, bus.resp_z, exp_z); end
    end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL fair_ready_idle got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 4'b1000) begin n_bad++; $display("FAIL fair_last_resp got %b want 1000", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b0) begin n_bad++; $display("FAIL fair_last_z got %b want 0", bus.resp_z); end
    @(negedge clk);
    #1;
    n_cmp++; if (cmp_count !== 16'd8) begin n_bad++; $display("FAIL fair_count got %0d want 8", cmp_count); end
  endtask

  // Pointer 0 after fairness. Grant 2 moves it to 3; then {1,0} valid gives
  // grant 0 (wrap), then 1, leaving the pointer at 2, seen when all are valid.
  task automatic test_wrap_skip();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_data  = {8'h01, 8'hFF, 8'hFF, 8'h10};
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_ready_a got %b want 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0011;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_ready_b got %b want 0001", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 4'b0100) begin n_bad++; $display("FAIL wrap_resp_a got %b want 0100", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b0) begin n_bad++; $display("FAIL wrap_z_a got %b want 0", bus.resp_z); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ready_c got %b want 0010", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 4'b0001) begin n_bad++; $display("FAIL wrap_resp_b got %b want 0001", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b1) begin n_bad++; $display("FAIL wrap_z_b got %b want 1", bus.resp_z); end
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_ptr2 got %b want 0100", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 4'b0010) begin n_bad++; $display("FAIL wrap_resp_c got %b want 0010", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 1'b0) begin n_bad++; $display("FAIL wrap_z_c got %b want 0", bus.resp_z); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0100) begin n_bad++; $display("FAIL wrap_resp_d got %b want 0100", bus.resp_valid); end
  endtask

  // Pointer 3; requester 0 granted (pointer would become 1), then reset hits
  // before the response cycle is sampled.
  task automatic test_reset_midflight();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h00};
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ready got %b want 0001", bus.req_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_resp_valid got %b want 0000", bus.resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (cmp_count !== 16'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", cmp_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_no_pulse got %b want 0000", bus.resp_valid); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr0 got %b want 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
  endtask

  // Back-to-back compares from a fresh reset. At falling edge k the counter
  // has seen k-1 response cycles: FFFE at k=65535, FFFF at k=65536, and it
  // must stay FFFF afterwards instead of wrapping.
  task automatic test_saturation();
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k <= 65537; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k == 65535) begin
        n_cmp++; if (cmp_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre got %h want fffe", cmp_count); end
      end
      if (k == 65536) begin
        n_cmp++; if (cmp_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h want ffff", cmp_count); end
      end
      if (k == 65537) begin
        n_cmp++; if (cmp_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", cmp_count); end
      end
    end
    bus.req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (cmp_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_idle got %h want ffff", cmp_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_busy got %b want 0", busy); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_all_ones();
    test_fairness();
    test_wrap_skip();
    test_reset_midflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
